// File: rtl/prog_ram_pkg.sv
// rtl/prog_ram_pkg.sv - state encodings and default widths shared by the prog_ram files
package prog_ram_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int DLY_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

endpackage

// File: rtl/prog_ram_if.sv
// rtl/prog_ram_if.sv - CPU port and loader stream bundle between the host side and prog_ram
interface prog_ram_if
  import prog_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_wr_en;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              reload;
  logic              cpu_start;
  logic [ADDR_W:0]   load_cnt;
  logic              running;

  modport master (
    output cpu_addr, cpu_wr_en, cpu_wdata, ld_valid, ld_data, ld_last, reload,
    input  cpu_rdata, ld_ready, cpu_start, load_cnt, running
  );

  modport slave (
    input  cpu_addr, cpu_wr_en, cpu_wdata, ld_valid, ld_data, ld_last, reload,
    output cpu_rdata, ld_ready, cpu_start, load_cnt, running
  );

endinterface

// File: rtl/prog_ram_mem.sv
// rtl/prog_ram_mem.sv - DEPTH x DATA_W register array, async clear, one write and one combinational read port
module prog_ram_mem
  import prog_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Zero-latency read: a same-cycle store is only visible after the edge.
  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/prog_ram.sv
// rtl/prog_ram.sv - program RAM with byte-stream loader, start-delay counter and one-shot cpu_start
module prog_ram
  import prog_ram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int START_DLY = 2
) (
  input  logic         clk,
  input  logic         reset,
  prog_ram_if.slave    bus
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [DLY_W-1:0]  DLY_END  = DLY_W'(START_DLY);
  localparam logic [DLY_W-1:0]  DLY_ONE  = DLY_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q,   ptr_d;
  logic [ADDR_W:0]     cnt_q,   cnt_d;
  logic [DLY_W-1:0]    dly_q,   dly_d;

  logic                ld_ready;
  logic                cpu_start;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    dly_d     = dly_q;
    ld_ready  = 1'b0;
    cpu_start = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = bus.ld_data;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_LOAD;
        ptr_d   = '0;
        cnt_d   = '0;
      end

      ST_LOAD: begin
        ld_ready = 1'b1;
        // A reload wins over a byte offered in the same cycle; that byte is dropped.
        if (bus.reload) begin
          ptr_d = '0;
          cnt_d = '0;
        end else if (bus.ld_valid) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + CNT_ONE;
          if (ptr_q != PTR_LAST) begin
            ptr_d = ptr_q + PTR_ONE;
          end
          if (bus.ld_last || (ptr_q == PTR_LAST)) begin
            state_d = ST_WAIT;
            dly_d   = '0;
          end
        end
      end

      ST_WAIT: begin
        if (bus.reload) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end else if (dly_q == DLY_END) begin
          cpu_start = 1'b1;
          state_d   = ST_RUN;
        end else begin
          dly_d = dly_q + DLY_ONE;
        end
      end

      ST_RUN: begin
        if (bus.reload) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end else if (bus.cpu_wr_en) begin
          mem_we    = 1'b1;
          mem_waddr = bus.cpu_addr;
          mem_wdata = bus.cpu_wdata;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
    end
  end

  prog_ram_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (mem_we),
    .wr_addr (mem_waddr),
    .wr_data (mem_wdata),
    .rd_addr (bus.cpu_addr),
    .rd_data (bus.cpu_rdata)
  );

  assign bus.ld_ready  = ld_ready;
  assign bus.cpu_start = cpu_start;
  assign bus.load_cnt  = cnt_q;
  assign bus.running   = (state_q == ST_RUN);

endmodule

// File: tb/tb_prog_ram.sv
// tb/tb_prog_ram.sv - directed bench for prog_ram loader, start pulse, CPU port and reset behaviour
`timescale 1ns/1ps
module tb_prog_ram;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  prog_ram_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  prog_ram #(
    .ADDR_W    (4),
    .DATA_W    (8),
    .START_DLY (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mem_rd(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    @(negedge clk);
    bus.cpu_addr = addr;
    #1;
    check($sformatf("%s[%0d]", tag, addr), 32'(bus.cpu_rdata), exp);
  endtask

  task automatic send(input logic v, input logic [7:0] d, input logic last, output logic rdy);
    @(negedge clk);
    bus.ld_valid = v;
    bus.ld_data  = d;
    bus.ld_last  = last;
    #1;
    rdy = bus.ld_ready;
  endtask

  task automatic watch_start(output int pulses, output int at);
    pulses = 0;
    at     = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
      #1;
      if (bus.cpu_start) begin
        pulses++;
        at = k;
      end
    end
  endtask

  task automatic do_reload();
    @(negedge clk);
    bus.reload = 1'b1;
    @(negedge clk);
    bus.reload = 1'b0;
  endtask

  initial begin
    logic [7:0] t1 [4];
    logic [7:0] bp_data [5];
    logic       bp_valid [5];
    logic       bp_last [5];
    logic       rdy;
    int         pulses;
    int         at;
    int         acc;

    t1       = '{8'h1E, 8'h2F, 8'hE0, 8'hF0};
    bp_data  = '{8'h31, 8'hEE, 8'h32, 8'hEE, 8'h33};
    bp_valid = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bp_last  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    reset         = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wr_en = 1'b0;
    bus.cpu_wdata = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.ld_last   = 1'b0;
    bus.reload    = 1'b0;

    @(negedge clk);
    #1;
    check("rst_ld_ready", 32'(bus.ld_ready), 0);
    check("rst_cpu_start", 32'(bus.cpu_start), 0);
    check("rst_load_cnt", 32'(bus.load_cnt), 0);
    check("rst_running", 32'(bus.running), 0);
    check("rst_rdata", 32'(bus.cpu_rdata), 0);
    @(negedge clk);
    reset = 1'b1;

    // First program, last byte flagged, valid held high
    for (int i = 0; i < 4; i++) begin
      send(1'b1, t1[i], (i == 3), rdy);
      check($sformatf("t1_ready%0d", i), 32'(rdy), 1);
    end
    watch_start(pulses, at);
    check("t1_start_pulses", 32'(pulses), 1);
    check("t1_start_cycle", 32'(at), 3);
    check("t1_running", 32'(bus.running), 1);
    check("t1_load_cnt", 32'(bus.load_cnt), 4);
    for (int i = 0; i < 4; i++) begin
      mem_rd("t1_mem", 4'(i), 32'(t1[i]));
    end

    // CPU store in RUN: old value until the edge
    @(negedge clk);
    bus.cpu_addr  = 4'hE;
    bus.cpu_wdata = 8'h5A;
    bus.cpu_wr_en = 1'b1;
    #1;
    check("run_wr_old", 32'(bus.cpu_rdata), 0);
    @(negedge clk);
    bus.cpu_wr_en = 1'b0;
    #1;
    check("run_wr_new", 32'(bus.cpu_rdata), 32'h5A);

    // Reload during RUN, stray CPU store in LOAD, two-byte program
    do_reload();
    bus.cpu_addr  = 4'h5;
    bus.cpu_wdata = 8'h77;
    bus.cpu_wr_en = 1'b1;
    #1;
    check("rl_ready", 32'(bus.ld_ready), 1);
    check("rl_cnt_clear", 32'(bus.load_cnt), 0);
    check("rl_running", 32'(bus.running), 0);
    send(1'b1, 8'hAA, 1'b0, rdy);
    bus.cpu_wr_en = 1'b0;
    send(1'b1, 8'hBB, 1'b1, rdy);
    watch_start(pulses, at);
    check("rl_start_pulses", 32'(pulses), 1);
    check("rl_load_cnt", 32'(bus.load_cnt), 2);
    mem_rd("rl_mem", 4'h0, 32'hAA);
    mem_rd("rl_mem", 4'h1, 32'hBB);
    mem_rd("rl_mem", 4'h2, 32'hE0);
    mem_rd("rl_mem", 4'h3, 32'hF0);
    mem_rd("rl_mem", 4'h5, 32'h00);
    mem_rd("rl_mem", 4'hE, 32'h5A);

    // Over-long stream: only DEPTH bytes accepted
    do_reload();
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      send(1'b1, 8'(i), 1'b0, rdy);
      if (rdy) acc++;
      if (i == 15) check("ovf_ready15", 32'(rdy), 1);
      if (i == 16) check("ovf_ready16", 32'(rdy), 0);
    end
    @(negedge clk);
    bus.ld_valid = 1'b0;
    #1;
    check("ovf_accepted", 32'(acc), 16);
    check("ovf_running", 32'(bus.running), 1);
    check("ovf_load_cnt", 32'(bus.load_cnt), 16);
    mem_rd("ovf_mem", 4'hF, 32'h0F);
    mem_rd("ovf_mem", 4'h0, 32'h00);
    mem_rd("ovf_mem", 4'hE, 32'h0E);

    // Backpressure: gaps carry junk data and ld_last that must be ignored
    do_reload();
    for (int i = 0; i < 5; i++) begin
      send(bp_valid[i], bp_data[i], bp_last[i], rdy);
    end
    watch_start(pulses, at);
    check("bp_start_pulses", 32'(pulses), 1);
    check("bp_load_cnt", 32'(bus.load_cnt), 3);
    mem_rd("bp_mem", 4'h0, 32'h31);
    mem_rd("bp_mem", 4'h1, 32'h32);
    mem_rd("bp_mem", 4'h2, 32'h33);
    mem_rd("bp_mem", 4'h3, 32'h03);

    // Reset mid-load clears everything at once
    do_reload();
    send(1'b1, 8'h55, 1'b0, rdy);
    send(1'b1, 8'h66, 1'b0, rdy);
    @(negedge clk);
    bus.ld_valid = 1'b0;
    reset        = 1'b0;
    #1;
    check("mrst_ld_ready", 32'(bus.ld_ready), 0);
    check("mrst_load_cnt", 32'(bus.load_cnt), 0);
    check("mrst_running", 32'(bus.running), 0);
    check("mrst_cpu_start", 32'(bus.cpu_start), 0);
    for (int i = 0; i < 16; i++) begin
      mem_rd("mrst_mem", 4'(i), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    send(1'b1, 8'h99, 1'b1, rdy);
    check("mrst_resume_ready", 32'(rdy), 1);
    watch_start(pulses, at);
    check("mrst_start_pulses", 32'(pulses), 1);
    check("mrst_load_cnt1", 32'(bus.load_cnt), 1);
    mem_rd("mrst_mem_after", 4'h0, 32'h99);
    mem_rd("mrst_mem_after", 4'h1, 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
